// File: rtl/d_fifo_param.sv
// Parametrised valid/ready FIFO for CGRA processing-element links.
// Supports first-word-fall-through or registered-read output, occupancy count and almost flags.
module d_fifo_param #(
   parameter int dataWidth        = 32,
   parameter int fifoDepth        = 32,
   parameter int fwft             = 1,
   parameter int almostFullLevel  = 28,
   parameter int almostEmptyLevel = 2
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [dataWidth-1:0]               din,
   input  logic                               dinValid,
   output logic                               dinReady,
   output logic [dataWidth-1:0]               dout,
   output logic                               doutValid,
   input  logic                               doutReady,
   output logic [$clog2(fifoDepth+1)-1:0]     count,
   output logic                               almostFull,
   output logic                               almostEmpty
);

   localparam int PW = ($clog2(fifoDepth) > 1) ? $clog2(fifoDepth) : 1;
   localparam int CW = $clog2(fifoDepth + 1);

   logic [dataWidth-1:0] mem [fifoDepth];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] rd_ptr_next;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   logic full;
   logic empty;
   logic wr_en;
   logic rd_en;

   assign full  = (count_reg == CW'(fifoDepth));
   assign empty = (count_reg == '0);

   // Acceptance is decided purely from registered occupancy, so a full FIFO
   // refuses a write even when a read is accepted in the same cycle.
   assign wr_en = dinValid && !full;
   assign rd_en = doutReady && !empty;

   assign dinReady    = !full;
   assign count       = count_reg;
   assign almostFull  = (count_reg >= CW'(almostFullLevel));
   assign almostEmpty = (count_reg <= CW'(almostEmptyLevel));

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_next = (wr_ptr_reg == PW'(fifoDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_next = (rd_ptr_reg == PW'(fifoDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
         end
         if (wr_en && !rd_en) begin
            count_next = count_reg + 1'b1;
         end else if (rd_en && !wr_en) begin
            count_next = count_reg - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage is never reset or cleared; occupancy alone defines valid contents.
   always_ff @(posedge clock) begin
      if (wr_en && !flush) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   generate
      if (fwft != 0) begin : g_fwft
         assign doutValid = !empty;
         assign dout      = doutValid ? mem[rd_ptr_reg] : '0;
      end else begin : g_regread
         logic [dataWidth-1:0] dout_reg;
         logic                 dout_valid_reg;

         // doutValid is a one-cycle pulse per accepted read; dout holds between reads.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               dout_reg       <= '0;
               dout_valid_reg <= 1'b0;
            end else if (flush) begin
               dout_valid_reg <= 1'b0;
            end else if (rd_en) begin
               dout_reg       <= mem[rd_ptr_reg];
               dout_valid_reg <= 1'b1;
            end else begin
               dout_valid_reg <= 1'b0;
            end
         end

         assign dout      = dout_reg;
         assign doutValid = dout_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_d_fifo_param.sv
// Directed bench for d_fifo_param: FWFT depth 4, registered-read depth 4,
// and FWFT depth 5 instances sharing one clock and reset.
module tb_d_fifo_param;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   // instance A: fwft=1, depth 4, almostFull at 3, almostEmpty at 1
   logic       a_flush, a_dv, a_dr, a_ov, a_or, a_af, a_ae;
   logic [7:0] a_din, a_dout;
   logic [2:0] a_cnt;
   // instance B: fwft=0, depth 4
   logic       b_flush, b_dv, b_dr, b_ov, b_or, b_af, b_ae;
   logic [7:0] b_din, b_dout;
   logic [2:0] b_cnt;
   // instance C: fwft=1, depth 5
   logic       c_flush, c_dv, c_dr, c_ov, c_or, c_af, c_ae;
   logic [7:0] c_din, c_dout;
   logic [2:0] c_cnt;

   d_fifo_param #(.dataWidth(8), .fifoDepth(4), .fwft(1), .almostFullLevel(3), .almostEmptyLevel(1)) u_a (
      .clock(clk), .reset(rst_n), .flush(a_flush), .din(a_din), .dinValid(a_dv), .dinReady(a_dr),
      .dout(a_dout), .doutValid(a_ov), .doutReady(a_or), .count(a_cnt), .almostFull(a_af), .almostEmpty(a_ae));

   d_fifo_param #(.dataWidth(8), .fifoDepth(4), .fwft(0), .almostFullLevel(3), .almostEmptyLevel(1)) u_b (
      .clock(clk), .reset(rst_n), .flush(b_flush), .din(b_din), .dinValid(b_dv), .dinReady(b_dr),
      .dout(b_dout), .doutValid(b_ov), .doutReady(b_or), .count(b_cnt), .almostFull(b_af), .almostEmpty(b_ae));

   d_fifo_param #(.dataWidth(8), .fifoDepth(5), .fwft(1), .almostFullLevel(4), .almostEmptyLevel(1)) u_c (
      .clock(clk), .reset(rst_n), .flush(c_flush), .din(c_din), .dinValid(c_dv), .dinReady(c_dr),
      .dout(c_dout), .doutValid(c_ov), .doutReady(c_or), .count(c_cnt), .almostFull(c_af), .almostEmpty(c_ae));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n) begin
         assert (a_cnt <= 3'd4 && b_cnt <= 3'd4 && c_cnt <= 3'd5)
            else $error("count exceeded depth: a=%0d b=%0d c=%0d", a_cnt, b_cnt, c_cnt);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      a_flush = 0; a_dv = 0; a_or = 0; a_din = '0;
      b_flush = 0; b_dv = 0; b_or = 0; b_din = '0;
      c_flush = 0; c_dv = 0; c_or = 0; c_din = '0;
      #12;
      checks++; if (a_dr !== 1'b1)  begin errors++; $display("FAIL reset_dinReady: got %b exp 1", a_dr); end
      checks++; if (a_ov !== 1'b0)  begin errors++; $display("FAIL reset_doutValid: got %b exp 0", a_ov); end
      checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h exp 00", a_dout); end
      checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", a_cnt); end
      checks++; if (a_ae !== 1'b1)  begin errors++; $display("FAIL reset_almostEmpty: got %b exp 1", a_ae); end
      checks++; if (a_af !== 1'b0)  begin errors++; $display("FAIL reset_almostFull: got %b exp 0", a_af); end
      checks++; if (b_ov !== 1'b0 || b_dout !== 8'h00) begin errors++; $display("FAIL reset_regread_out: got v=%b d=%h exp v=0 d=00", b_ov, b_dout); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fwft_fill_drain;
      for (int i = 0; i < 4; i++) begin
         a_din = 8'hA1 + 8'(i); a_dv = 1'b1;
         tick();
         checks++; if (a_cnt !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d exp %0d", i, a_cnt, i + 1); end
         checks++; if (a_af !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_almostFull[%0d]: got %b exp %b", i, a_af, (i + 1 >= 3)); end
         checks++; if (a_ae !== (i + 1 <= 1)) begin errors++; $display("FAIL fill_almostEmpty[%0d]: got %b exp %b", i, a_ae, (i + 1 <= 1)); end
      end
      checks++; if (a_dr !== 1'b0) begin errors++; $display("FAIL full_dinReady: got %b exp 0", a_dr); end
      checks++; if (a_ov !== 1'b1 || a_dout !== 8'hA1) begin errors++; $display("FAIL fwft_head: got v=%b d=%h exp v=1 d=a1", a_ov, a_dout); end
      a_din = 8'hA5;
      tick();
      checks++; if (a_cnt !== 3'd4) begin errors++; $display("FAIL refused_write_count: got %0d exp 4", a_cnt); end
      a_dv = 1'b0; a_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_ov !== 1'b1 || a_dout !== 8'hA1 + 8'(i)) begin errors++; $display("FAIL drain[%0d]: got v=%b d=%h exp v=1 d=%h", i, a_ov, a_dout, 8'hA1 + 8'(i)); end
         tick();
      end
      a_or = 1'b0;
      checks++; if (a_ov !== 1'b0 || a_cnt !== 3'd0 || a_dout !== 8'h00) begin errors++; $display("FAIL drained: got v=%b c=%0d d=%h exp v=0 c=0 d=00", a_ov, a_cnt, a_dout); end
   endtask

   task automatic test_regread;
      b_din = 8'h11; b_dv = 1'b1; tick();
      b_din = 8'h22; tick();
      b_dv = 1'b0;
      checks++; if (b_ov !== 1'b0 || b_cnt !== 3'd2) begin errors++; $display("FAIL rr_loaded: got v=%b c=%0d exp v=0 c=2", b_ov, b_cnt); end
      b_or = 1'b1; tick(); b_or = 1'b0;
      checks++; if (b_ov !== 1'b1 || b_dout !== 8'h11 || b_cnt !== 3'd1) begin errors++; $display("FAIL rr_first: got v=%b d=%h c=%0d exp v=1 d=11 c=1", b_ov, b_dout, b_cnt); end
      tick();
      checks++; if (b_ov !== 1'b0 || b_dout !== 8'h11) begin errors++; $display("FAIL rr_pulse_end: got v=%b d=%h exp v=0 d=11", b_ov, b_dout); end
      b_or = 1'b1; tick();
      checks++; if (b_ov !== 1'b1 || b_dout !== 8'h22 || b_cnt !== 3'd0) begin errors++; $display("FAIL rr_second: got v=%b d=%h c=%0d exp v=1 d=22 c=0", b_ov, b_dout, b_cnt); end
      tick(); b_or = 1'b0;
      checks++; if (b_ov !== 1'b0 || b_dout !== 8'h22) begin errors++; $display("FAIL rr_empty_read: got v=%b d=%h exp v=0 d=22", b_ov, b_dout); end
   endtask

   task automatic test_wrap_depth5;
      int wr;
      int rd;
      logic wr_acc;
      wr = 0; rd = 0;
      c_din = 8'd0; c_dv = 1'b1; c_or = 1'b1;
      for (int cyc = 0; cyc < 100 && rd < 20; cyc++) begin
         if (c_ov) begin
            checks++; if (c_dout !== 8'(rd)) begin errors++; $display("FAIL wrap_order[%0d]: got %0d exp %0d", rd, c_dout, rd); end
            rd++;
         end
         wr_acc = c_dv && c_dr;
         tick();
         if (wr_acc) wr++;
         c_din = 8'(wr);
         c_dv = (wr < 20);
         checks++; if (c_cnt > 3'd1) begin errors++; $display("FAIL wrap_count: got %0d exp <=1", c_cnt); end
      end
      c_dv = 1'b0; c_or = 1'b0;
      checks++; if (rd !== 20) begin errors++; $display("FAIL wrap_timeout: got %0d words exp 20", rd); end
      checks++; if (c_cnt !== 3'd0) begin errors++; $display("FAIL wrap_final_count: got %0d exp 0", c_cnt); end
   endtask

   task automatic test_full_simul;
      a_dv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_din = 8'h31 + 8'(i); tick();
      end
      a_din = 8'h35; a_or = 1'b1;
      tick();
      a_or = 1'b0;
      checks++; if (a_cnt !== 3'd3 || a_dout !== 8'h32) begin errors++; $display("FAIL full_rw: got c=%0d d=%h exp c=3 d=32", a_cnt, a_dout); end
      tick();
      a_dv = 1'b0;
      checks++; if (a_cnt !== 3'd4 || a_dr !== 1'b0) begin errors++; $display("FAIL full_refill: got c=%0d r=%b exp c=4 r=0", a_cnt, a_dr); end
      a_or = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_dout !== 8'h32 + 8'(i)) begin errors++; $display("FAIL full_drain[%0d]: got %h exp %h", i, a_dout, 8'h32 + 8'(i)); end
         tick();
      end
      a_or = 1'b0;
      checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL full_drain_count: got %0d exp 0", a_cnt); end
   endtask

   task automatic test_flush;
      a_dv = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_din = 8'hC1 + 8'(i); tick();
      end
      a_din = 8'hC4; a_flush = 1'b1; a_or = 1'b1;
      tick();
      a_flush = 1'b0; a_dv = 1'b0; a_or = 1'b0;
      checks++; if (a_cnt !== 3'd0 || a_ov !== 1'b0 || a_ae !== 1'b1) begin errors++; $display("FAIL flush_state: got c=%0d v=%b ae=%b exp c=0 v=0 ae=1", a_cnt, a_ov, a_ae); end
      a_din = 8'h5A; a_dv = 1'b1; tick(); a_dv = 1'b0;
      checks++; if (a_ov !== 1'b1 || a_dout !== 8'h5A || a_cnt !== 3'd1) begin errors++; $display("FAIL flush_next_word: got v=%b d=%h c=%0d exp v=1 d=5a c=1", a_ov, a_dout, a_cnt); end
      a_or = 1'b1; tick(); a_or = 1'b0;
      b_din = 8'h77; b_dv = 1'b1; tick(); b_dv = 1'b0;
      b_or = 1'b1; tick(); b_or = 1'b0;
      b_flush = 1'b1; tick(); b_flush = 1'b0;
      checks++; if (b_ov !== 1'b0 || b_dout !== 8'h77 || b_cnt !== 3'd0) begin errors++; $display("FAIL rr_flush: got v=%b d=%h c=%0d exp v=0 d=77 c=0", b_ov, b_dout, b_cnt); end
   endtask

   task automatic test_async_reset;
      a_dv = 1'b1;
      a_din = 8'hE1; tick();
      a_din = 8'hE2; tick();
      a_din = 8'hE3;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (a_ov !== 1'b0 || a_dout !== 8'h00 || a_cnt !== 3'd0 || a_dr !== 1'b1) begin errors++; $display("FAIL async_reset: got v=%b d=%h c=%0d r=%b exp v=0 d=00 c=0 r=1", a_ov, a_dout, a_cnt, a_dr); end
      a_dv = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (a_cnt !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d exp 0", a_cnt); end
      a_din = 8'hF0; a_dv = 1'b1; tick(); a_dv = 1'b0;
      checks++; if (a_ov !== 1'b1 || a_dout !== 8'hF0) begin errors++; $display("FAIL post_reset_write: got v=%b d=%h exp v=1 d=f0", a_ov, a_dout); end
      a_or = 1'b1; tick(); a_or = 1'b0;
      checks++; if (a_cnt !== 3'd0 || a_ov !== 1'b0) begin errors++; $display("FAIL post_reset_read: got c=%0d v=%b exp c=0 v=0", a_cnt, a_ov); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fwft_fill_drain();
      test_regread();
      test_wrap_depth5();
      test_full_simul();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
